// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: valid/ready request in, one registered response out.
// Define DMEM_RESP_ERR_EN to flag out-of-range and misaligned word requests with rsp_err.
module data_mem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_byte;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_hs;
    logic [AW-1:0] w_idx;
    logic [4:0]    w_shift;
    logic [31:0]   w_word;
    logic [7:0]    w_lane;
    logic          w_err;

    assign w_hs    = req_valid && (r_state == S_IDLE);
    assign w_idx   = r_addr[AW+1:2];
    // Lane 0 is the most significant byte, so the bit offset is (3 - lane) * 8.
    assign w_shift = {~r_addr[1:0], 3'b000};
    assign w_word  = r_mem[w_idx];
    assign w_lane  = w_word[w_shift +: 8];

`ifdef DMEM_RESP_ERR_EN
    assign w_err = (|r_addr[31:AW+2]) || (!r_byte && (r_addr[1:0] != 2'b00));
`else
    logic w_unused_addr;
    assign w_unused_addr = ^r_addr[31:AW+2];
    assign w_err         = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_next_state = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_cnt == 4'd0) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   if (rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        rsp_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            if (w_hs) begin
                r_cnt   <= CNT_INIT;
                r_we    <= req_we;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response fields only change on the ACCESS edge, so they hold through RESP and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_err <= w_err;
            if (w_err || r_we) r_rdata <= 32'd0;
            else if (r_byte)   r_rdata <= {24'd0, w_lane};
            else               r_rdata <= w_word;
        end
    end

    // NOTE: the storage must clear on reset, so it is a register array with a reset loop, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (r_state == S_ACCESS && r_we && !w_err) begin
            if (r_byte) r_mem[w_idx][w_shift +: 8] <= r_wdata[7:0];
            else        r_mem[w_idx]               <= r_wdata;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a response scoreboard queue.
// Covers reset, word/byte access, latency, backpressure, mid-op reset and addressing mode.
module tb_data_mem_responder;

    parameter int DEPTH       = 32;
    parameter int WAIT_CYCLES = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t sb_q[$];

    data_mem_responder #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_byte (req_byte),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request, scrambles the inputs after the handshake, optionally stalls the
    // response for 'stall' cycles, then compares against the scoreboard head.
    task automatic txn(input string tag, input logic we, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int stall);
        rsp_t e;
        int   lat;
        int   guard;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_byte  = ~bt;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 2));
        e = sb_q.pop_front();
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_stall_req_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_stall_rdata"}, rsp_rdata, e.rdata);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
    endtask

    // Starts a store and asserts reset while the FSM sits in ACCESS.
    task automatic reset_in_access(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < WAIT_CYCLES + 1; i++) @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);

        txn("st_word", 1'b1, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        txn("ld_word", 1'b0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        txn("st_byte", 1'b1, 1'b1, 32'h09, 32'hFFFFFF5A, 32'h0, 1'b0, 0);
        txn("ld_merged", 1'b0, 1'b0, 32'h08, 32'h0, 32'hDE5ABEEF, 1'b0, 1);
        txn("ld_byte3", 1'b0, 1'b1, 32'h0B, 32'h0, 32'h000000EF, 1'b0, 0);
        txn("ld_byte0", 1'b0, 1'b1, 32'h08, 32'h0, 32'h000000DE, 1'b0, 0);
        txn("ld_byte1", 1'b0, 1'b1, 32'h09, 32'h0, 32'h0000005A, 1'b0, 0);

`ifdef DMEM_RESP_ERR_EN
        txn("err_st_range", 1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        txn("err_ld_zero", 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 0);
        txn("err_ld_misal", 1'b0, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 2);
        txn("err_byte_ok", 1'b0, 1'b1, 32'h09, 32'h0, 32'h0000005A, 1'b0, 0);
`else
        txn("wrap_st", 1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        txn("wrap_ld", 1'b0, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        txn("misal_ld", 1'b0, 1'b0, 32'h0A, 32'h0, 32'hDE5ABEEF, 1'b0, 0);
`endif

        txn("pre_rst_st", 1'b1, 1'b0, 32'h0C, 32'h11111111, 32'h0, 1'b0, 0);
        reset_in_access(32'h04, 32'h12345678);
        txn("post_rst_ld4", 1'b0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 0);
        txn("post_rst_ldc", 1'b0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 0);
        txn("post_rst_ld8", 1'b0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 32, SHALL be the number of 32-bit storage words (power of two, 2..256).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL be the wait states inserted before each access (0..15).
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  in  1  SHALL indicate the initiator presents a request.
REQ-006 req_ready  out  1  SHALL indicate the responder accepts a request this cycle.
REQ-007 req_we  in  1  SHALL select store (1) or load (0).
REQ-008 req_byte  in  1  SHALL select byte access (1) or word access (0).
REQ-009 req_addr  in  32  SHALL be the byte address.
REQ-010 req_wdata  in  32  SHALL be the store data; byte stores use bits [7:0].
REQ-011 rsp_valid  out  1  SHALL indicate a response is presented.
REQ-012 rsp_ready  in  1  SHALL indicate the initiator accepts the response.
REQ-013 rsp_rdata  out  32  SHALL be the load data; 0 for stores.
REQ-014 rsp_err  out  1  SHALL flag an errored request; qualified by rsp_valid.
REQ-015 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, ACCESS and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1.
REQ-018 On handshake, we/byte/addr/wdata SHALL be latched, and the FSM SHALL enter WAIT with counter = WAIT_CYCLES-1, or ACCESS directly if WAIT_CYCLES = 0.
REQ-019 WAIT SHALL decrement the counter each cycle and enter ACCESS when the counter is 0.
REQ-020 ACCESS SHALL last exactly one cycle, perform the read or write on its closing edge, register rsp_rdata, and enter RESP.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2]; byte lane SHALL be addr[1:0], with lane 0 = bits [31:24] and lane 3 = bits [7:0].
REQ-022 A word load SHALL return the full word; a byte load SHALL return {24'd0, selected lane}.
REQ-023 A word store SHALL write all 32 bits; a byte store SHALL write wdata[7:0] into the selected lane only, leaving the other lanes unchanged.
REQ-024 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL stay stable until rsp_ready is 1; the FSM then returns to IDLE on that edge.
REQ-025 Latency: rsp_valid SHALL first assert exactly WAIT_CYCLES+2 cycles after the handshake cycle.
REQ-026 Back-to-back: the next request SHALL be accepted no earlier than the cycle after the RESP handshake.
REQ-027 Inputs changing after the handshake SHALL NOT affect the transaction in flight.
REQ-028 Outside RESP, rsp_valid SHALL be 0, and rsp_rdata and rsp_err SHALL hold their last values.

Reset
REQ-029 On rst = 1 at a clock edge: the FSM SHALL go to IDLE, the counter to 0, rsp_valid/rsp_err/busy to 0, rsp_rdata to 0, and all storage words to 0.
REQ-030 In the cycle after reset, req_ready SHALL be 1.
REQ-031 A reset mid-transaction, including in ACCESS, SHALL abort it with no memory write and no response.

Configuration
REQ-032 Macro DMEM_RESP_ERR_EN defined: a request SHALL be errored if the word index (addr>>2) >= DEPTH, or if it is a word access with addr[1:0] != 0.
REQ-033 An errored request SHALL complete with full latency, rsp_err = 1, rsp_rdata = 0, and no memory write.
REQ-034 Macro undefined: addresses SHALL wrap modulo DEPTH words, addr[1:0] SHALL be ignored for word access, and rsp_err SHALL be tied to 0 (port retained).

Verification
REQ-035 Word store then load: store addr 0x08, data 0xDEADBEEF; load addr 0x08 -> rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-036 Byte access: after the REQ-035 store, byte store 0x5A to addr 0x09; word load 0x08 -> 0xDE5ABEEF; byte load 0x0B -> 0x000000EF.
REQ-037 Latency/backpressure: WAIT_CYCLES = 2, handshake at cycle 10 -> rsp_valid at cycle 14; rsp_ready held 0 for 3 cycles -> rsp_rdata stable, req_ready 0 throughout.
REQ-038 Reset mid-op: word store 0x12345678 to 0x04, rst asserted during ACCESS -> no response, load of 0x04 after reset returns 0.
REQ-039 Errors (DMEM_RESP_ERR_EN, DEPTH = 32): store to 0x80 -> rsp_err 1, memory unchanged; word load at 0x02 -> rsp_err 1, rsp_rdata 0; without macro, store 0x80 then load 0x00 -> stored data.
REQ-040 WAIT_CYCLES = 0: handshake at cycle 5 -> rsp_valid at cycle 7 with rsp_ready = 1, req_ready = 1 at cycle 8.
